// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage: 2-cycle multiply/accumulate,
// 32-step restoring divide, MTHI/MTLO writes, flush abort, registered busy stall.
//
// state | meaning
// IDLE  | waiting for a HI/LO op; MTHI/MTLO and divide-by-zero complete here
// MUL   | registered product applied to {hi,lo} (set / add / subtract)
// DIV   | one restoring-divide step per cycle, 32 steps
// FIX   | signs applied, quotient to lo, remainder to hi
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [7:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [7:0] INST_INVALID = 8'h00;
  localparam logic [7:0] INST_MUL     = 8'h20;
  localparam logic [7:0] INST_MULT    = 8'h21;
  localparam logic [7:0] INST_MULTU   = 8'h22;
  localparam logic [7:0] INST_MADD    = 8'h23;
  localparam logic [7:0] INST_MADDU   = 8'h24;
  localparam logic [7:0] INST_MSUB    = 8'h25;
  localparam logic [7:0] INST_MSUBU   = 8'h26;
  localparam logic [7:0] INST_DIV     = 8'h27;
  localparam logic [7:0] INST_DIVU    = 8'h28;
  localparam logic [7:0] INST_MTHI    = 8'h29;
  localparam logic [7:0] INST_MTLO    = 8'h2A;

  localparam logic [1:0] KIND_SET = 2'd0;
  localparam logic [1:0] KIND_ADD = 2'd1;
  localparam logic [1:0] KIND_SUB = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t state, state_nxt;

  logic        is_mul, is_div, is_mthi, is_mtlo, is_signed;
  logic [1:0]  kind_dec;
  logic        accept, mul_start, div_start;

  logic [63:0] prod;
  logic [1:0]  kind;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [4:0]  count;
  logic        q_neg, r_neg;

  logic [32:0] mul_a, mul_b;
  logic [65:0] prod_full;
  logic [32:0] rem_sh, trial;
  logic        q_bit;
  logic [31:0] rem_step;
  logic [31:0] rs_abs, rt_abs;

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    is_signed = 1'b0;
    kind_dec  = KIND_SET;
    case (op)
      INST_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
      INST_MULTU: is_mul = 1'b1;
      INST_MADD:  begin is_mul = 1'b1; is_signed = 1'b1; kind_dec = KIND_ADD; end
      INST_MADDU: begin is_mul = 1'b1; kind_dec = KIND_ADD; end
      INST_MSUB:  begin is_mul = 1'b1; is_signed = 1'b1; kind_dec = KIND_SUB; end
      INST_MSUBU: begin is_mul = 1'b1; kind_dec = KIND_SUB; end
      INST_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
      INST_DIVU:  is_div = 1'b1;
      INST_MTHI:  is_mthi = 1'b1;
      INST_MTLO:  is_mtlo = 1'b1;
      default:    ;
    endcase
  end

  assign accept    = op_valid && !busy && !flush && (is_mul || is_div || is_mthi || is_mtlo);
  assign mul_start = accept && is_mul;
  assign div_start = accept && is_div && (rt_val != 32'd0);

  // 33-bit operands let one signed multiplier serve both signed and unsigned forms.
  assign mul_a     = {is_signed & rs_val[31], rs_val};
  assign mul_b     = {is_signed & rt_val[31], rt_val};
  assign prod_full = $signed(mul_a) * $signed(mul_b);

  assign rs_abs = (is_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
  assign rt_abs = (is_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;

  assign rem_sh   = {rem, dvd[31]};
  assign trial    = rem_sh - {1'b0, dvs};
  assign q_bit    = ~trial[32];
  assign rem_step = q_bit ? trial[31:0] : rem_sh[31:0];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (mul_start)      state_nxt = S_MUL;
        else if (div_start) state_nxt = S_DIV;
      end
      S_MUL:   state_nxt = S_IDLE;
      S_DIV:   if (count == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush && state != S_IDLE) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi    <= 32'd0;
      lo    <= 32'd0;
      prod  <= 64'd0;
      kind  <= KIND_SET;
      dvd   <= 32'd0;
      dvs   <= 32'd0;
      rem   <= 32'd0;
      count <= 5'd0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && is_mthi) hi <= rs_val;
          if (accept && is_mtlo) lo <= rs_val;
          if (mul_start) begin
            prod <= prod_full[63:0];
            kind <= kind_dec;
          end
          if (div_start) begin
            dvd   <= rs_abs;
            dvs   <= rt_abs;
            rem   <= 32'd0;
            count <= 5'd0;
            q_neg <= is_signed & (rs_val[31] ^ rt_val[31]);
            r_neg <= is_signed & rs_val[31];
          end
        end
        S_MUL: begin
          if (!flush) begin
            case (kind)
              KIND_ADD: {hi, lo} <= {hi, lo} + prod;
              KIND_SUB: {hi, lo} <= {hi, lo} - prod;
              default:  {hi, lo} <= prod;
            endcase
          end
        end
        S_DIV: begin
          // dvd shifts out dividend bits at the top and collects quotient bits at the bottom.
          dvd   <= {dvd[30:0], q_bit};
          rem   <= rem_step;
          count <= count + 5'd1;
        end
        S_FIX: begin
          if (!flush) begin
            lo <= q_neg ? (~dvd + 32'd1) : dvd;
            hi <= r_neg ? (~rem + 32'd1) : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: hand-computed HI/LO results, busy lengths,
// flush/reset aborts and ignored ops.
module tb_hilo_muldiv_ctrl;

  localparam logic [7:0] INST_INVALID = 8'h00;
  localparam logic [7:0] INST_MUL     = 8'h20;
  localparam logic [7:0] INST_MULT    = 8'h21;
  localparam logic [7:0] INST_MULTU   = 8'h22;
  localparam logic [7:0] INST_MADD    = 8'h23;
  localparam logic [7:0] INST_MADDU   = 8'h24;
  localparam logic [7:0] INST_MSUB    = 8'h25;
  localparam logic [7:0] INST_MSUBU   = 8'h26;
  localparam logic [7:0] INST_DIV     = 8'h27;
  localparam logic [7:0] INST_DIVU    = 8'h28;
  localparam logic [7:0] INST_MTHI    = 8'h29;
  localparam logic [7:0] INST_MTLO    = 8'h2A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [7:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  hilo_muldiv_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents the op for one edge and returns at the following negedge.
  task automatic do_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op       = INST_INVALID;
  endtask

  // Counts negedges with busy high, bounded so a stuck busy still reaches the summary.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op       = INST_INVALID;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(INST_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle(cyc);
    check("mult_busy_cycles", cyc, 32'd1);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    do_op(INST_MULTU, 32'hFFFFFFFE, 32'd3);
    wait_idle(cyc);
    check("multu_hi", hi, 32'h00000002);
    check("multu_lo", lo, 32'hFFFFFFFA);

    do_op(INST_MTHI, 32'd0, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    do_op(INST_MTLO, 32'd10, 32'd0);
    check("mtlo_lo", lo, 32'd10);
    check("mthi_hi", hi, 32'd0);
    do_op(INST_MADDU, 32'd5, 32'd4);
    wait_idle(cyc);
    check("maddu_lo", lo, 32'd30);
    check("maddu_hi", hi, 32'd0);
    do_op(INST_MSUB, 32'd1, 32'd31);
    wait_idle(cyc);
    check("msub_lo", lo, 32'hFFFFFFFF);
    check("msub_hi", hi, 32'hFFFFFFFF);

    do_op(INST_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(cyc);
    check("div_busy_cycles", cyc, 32'd33);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    do_op(INST_DIVU, 32'd100, 32'd7);
    wait_idle(cyc);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    do_op(INST_MTHI, 32'h11, 32'd0);
    do_op(INST_MTLO, 32'h22, 32'd0);
    do_op(INST_DIVU, 32'd55, 32'd0);
    check("div0_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("div0_busy_later", {31'd0, busy}, 32'd0);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    do_op(INST_MUL, 32'd9, 32'd9);
    check("inst_mul_busy", {31'd0, busy}, 32'd0);
    check("inst_mul_lo", lo, 32'h22);

    flush = 1'b1;
    do_op(INST_MTHI, 32'hDEAD, 32'd0);
    flush = 1'b0;
    check("flush_idle_hi", hi, 32'h11);

    do_op(INST_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(cyc);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'd0);

    do_op(INST_MTHI, 32'hAAAA0001, 32'd0);
    do_op(INST_MTLO, 32'h5555000F, 32'd0);
    do_op(INST_DIVU, 32'd1000, 32'd3);
    op_valid = 1'b1;
    op       = INST_MULT;
    rs_val   = 32'd6;
    rt_val   = 32'd7;
    repeat (8) @(negedge clk);
    op_valid = 1'b0;
    op       = INST_INVALID;
    check("busy_at_cycle9", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_div_busy", {31'd0, busy}, 32'd0);
    check("flush_div_hi", hi, 32'hAAAA0001);
    check("flush_div_lo", lo, 32'h5555000F);
    @(negedge clk);
    check("ignored_mult_busy", {31'd0, busy}, 32'd0);

    do_op(INST_MADD, 32'd2, 32'd3);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_mul_busy", {31'd0, busy}, 32'd0);
    check("flush_mul_lo", lo, 32'h5555000F);

    do_op(INST_DIV, 32'd500, 32'd9);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    rst_n = 1'b1;
    do_op(INST_DIV, 32'hFFFFFF9C, 32'd7);
    wait_idle(cyc);
    check("post_rst_div_cycles", cyc, 32'd33);
    check("post_rst_div_lo", lo, 32'hFFFFFFF2);
    check("post_rst_div_hi", hi, 32'hFFFFFFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
